// File: rtl/instr_packer_pkg.sv
// Shared types and helpers for the instruction packer and the frontend re-aligner.
package instr_packer_pkg;

    localparam int unsigned FETCH_HALVES = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        DRAIN = 2'd2
    } instr_packer_state_e;

    function automatic logic is_compressed(input logic [1:0] opcode_lo);
        return opcode_lo != 2'b11;
    endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Fetch-block stream: one word-aligned 32-bit block with its address and half-word mask.
interface instr_packer_if #(
    parameter int unsigned VLEN = 32
);
    import instr_packer_pkg::*;

    logic                    fetch_valid;
    logic                    fetch_ready;
    logic [VLEN-1:0]         fetch_addr;
    logic [31:0]             fetch_data;
    logic [FETCH_HALVES-1:0] fetch_be;

    modport master (
        output fetch_valid, fetch_addr, fetch_data, fetch_be,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid, fetch_addr, fetch_data, fetch_be,
        output fetch_ready
    );

endinterface

// File: rtl/instr_packer_outreg.sv
// One-entry valid/ready output register; contents hold steady while stalled.
module instr_packer_outreg
    import instr_packer_pkg::*;
#(
    parameter int unsigned VLEN = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [VLEN-1:0]         addr_i,
    input  logic [31:0]             data_i,
    input  logic [FETCH_HALVES-1:0] be_i,
    output logic                    free_o,
    instr_packer_if.master          fetch
);

    logic                    valid_q;
    logic [VLEN-1:0]         addr_q;
    logic [31:0]             data_q;
    logic [FETCH_HALVES-1:0] be_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
            be_q    <= be_i;
        end else if (fetch.fetch_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Free when empty or being drained this cycle, which allows one word per cycle.
    assign free_o            = !valid_q || fetch.fetch_ready;
    assign fetch.fetch_valid = valid_q;
    assign fetch.fetch_addr  = addr_q;
    assign fetch.fetch_data  = data_q;
    assign fetch.fetch_be    = be_q;

endmodule

// File: rtl/instr_packer.sv
// Packs 16/32-bit RISC-V instructions back-to-back into word-aligned fetch blocks.
// Optional INSTR_PACKER_LEN_CHK_EN drops >=48-bit encodings and pulses err_o.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int unsigned VLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [VLEN-1:0] start_addr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic            last_i,
    instr_packer_if.master  fetch,
    output logic            err_o
);

    instr_packer_state_e state_q, state_d;
    logic [15:0]         half_q, half_d;
    logic                half_be_q, half_be_d;
    logic [VLEN-1:0]     addr_q, addr_d;
    logic                err_q, err_d;

    logic                    out_free;
    logic                    accept;
    logic                    comp;
    logic                    len_err;
    logic                    load;
    logic [31:0]             load_data;
    logic [FETCH_HALVES-1:0] load_be;

    assign comp          = is_compressed(instr_i[1:0]);
    assign instr_ready_o = !flush_i && (state_q != DRAIN) && out_free;
    assign accept        = instr_valid_i && instr_ready_o;

`ifdef INSTR_PACKER_LEN_CHK_EN
    assign len_err = !comp && (instr_i[4:2] == 3'b111);
`else
    assign len_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        half_be_d = half_be_q;
        addr_d    = addr_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_be   = '0;

        if (flush_i) begin
            // An odd start address begins with a padded (invalid) low half.
            addr_d    = {start_addr_i[VLEN-1:2], 2'b00};
            half_d    = '0;
            half_be_d = 1'b0;
            state_d   = start_addr_i[1] ? HALF : EMPTY;
        end else if (state_q == DRAIN) begin
            if (out_free) begin
                load      = 1'b1;
                load_data = {16'h0000, half_q};
                load_be   = 2'b01;
                addr_d    = addr_q + VLEN'(4);
                state_d   = EMPTY;
            end
        end else if (accept) begin
            if (len_err) begin
                err_d = 1'b1;
            end else begin
                if (state_q == EMPTY) begin
                    if (comp) begin
                        half_d    = instr_i[15:0];
                        half_be_d = 1'b1;
                        state_d   = HALF;
                    end else begin
                        load      = 1'b1;
                        load_data = instr_i;
                        load_be   = 2'b11;
                        addr_d    = addr_q + VLEN'(4);
                    end
                end else begin
                    load      = 1'b1;
                    load_data = {instr_i[15:0], half_q};
                    load_be   = {1'b1, half_be_q};
                    addr_d    = addr_q + VLEN'(4);
                    if (comp) begin
                        state_d = EMPTY;
                    end else begin
                        half_d    = instr_i[31:16];
                        half_be_d = 1'b1;
                    end
                end
                if (last_i && (state_d == HALF)) begin
                    state_d = DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            half_q    <= '0;
            half_be_q <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            half_be_q <= half_be_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    instr_packer_outreg #(
        .VLEN (VLEN)
    ) u_outreg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .load_i  (load),
        .addr_i  (addr_q),
        .data_i  (load_data),
        .be_i    (load_be),
        .free_o  (out_free),
        .fetch   (fetch)
    );

`ifndef SYNTHESIS
    a_start_even: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i |-> !start_addr_i[0]);
`endif

endmodule
